// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor, one full-subtractor cell reused N times, LSB first.
// Optional: define SUB_OVERFLOW_EN to add the signed-overflow output transbordo.
module subtrator_serial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inicio,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         emprestimo_entrada,
   output logic [N-1:0] diferenca,
   output logic         emprestimo_saida,
   output logic         ocupado,
`ifdef SUB_OVERFLOW_EN
   output logic         transbordo,
`endif
   output logic         concluido
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      OCIOSO,
      CALC,
      FIM
   } estado_t;

   estado_t state, next;

   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic          borrow;
   logic [CW-1:0] cnt;
   logic          d;
   logic          bout;
   logic          last;

`ifdef SUB_OVERFLOW_EN
   logic a_msb;
   logic b_msb;
`endif

   assign d    = sa[0] ^ sb[0] ^ borrow;
   assign bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
   assign last = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OCIOSO;
      else        state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         OCIOSO:  if (inicio) next = CALC;
         CALC:    if (last) next = FIM;
         FIM:     next = OCIOSO;
         default: next = OCIOSO;
      endcase
   end

   // sa doubles as the result register: difference bits enter at the top
   // while minuend bits leave at the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa               <= '0;
         sb               <= '0;
         borrow           <= 1'b0;
         cnt              <= '0;
         diferenca        <= '0;
         emprestimo_saida <= 1'b0;
         ocupado          <= 1'b0;
         concluido        <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         a_msb            <= 1'b0;
         b_msb            <= 1'b0;
         transbordo       <= 1'b0;
`endif
      end else begin
         ocupado   <= (next == CALC);
         concluido <= (state == CALC) && last;
         unique case (state)
            OCIOSO: begin
               if (inicio) begin
                  sa     <= a;
                  sb     <= b;
                  borrow <= emprestimo_entrada;
                  cnt    <= '0;
`ifdef SUB_OVERFLOW_EN
                  a_msb  <= a[N-1];
                  b_msb  <= b[N-1];
`endif
               end
            end
            CALC: begin
               sa     <= {d, sa[N-1:1]};
               sb     <= {1'b0, sb[N-1:1]};
               borrow <= bout;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  diferenca        <= {d, sa[N-1:1]};
                  emprestimo_saida <= bout;
`ifdef SUB_OVERFLOW_EN
                  transbordo <= (a_msb != b_msb) && (d != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (N=4): vector table, random
// operands against an arithmetic model, and multi-cycle handshake sequences.
module tb_subtrator_serial;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inicio = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         emprestimo_entrada = 1'b0;
   logic [N-1:0] diferenca;
   logic         emprestimo_saida;
   logic         ocupado;
   logic         concluido;
`ifdef SUB_OVERFLOW_EN
   logic         transbordo;
`endif

   int vectors = 0;
   int miscompares = 0;

   subtrator_serial #(.N(N)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .inicio             (inicio),
      .a                  (a),
      .b                  (b),
      .emprestimo_entrada (emprestimo_entrada),
      .diferenca          (diferenca),
      .emprestimo_saida   (emprestimo_saida),
      .ocupado            (ocupado),
`ifdef SUB_OVERFLOW_EN
      .transbordo         (transbordo),
`endif
      .concluido          (concluido)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         bin;
      logic [N-1:0] d;
      logic         bo;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: (N+1)-bit two's-complement difference.
   function automatic logic [N:0] model(input logic [N-1:0] x,
                                        input logic [N-1:0] y,
                                        input logic c);
      int r;
      r = int'(x) - int'(y) - int'(c);
      return (N+1)'(r);
   endfunction

   function automatic logic model_ovf(input logic [N-1:0] x,
                                      input logic [N-1:0] y,
                                      input logic [N-1:0] r);
      return (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
   endfunction

   // Launch one operation and wait (bounded) for concluido.
   task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                         input logic c, output int lat, output int busy,
                         output int pulse);
      @(negedge clk);
      a = xa;
      b = xb;
      emprestimo_entrada = c;
      inicio = 1'b1;
      lat = 99;
      busy = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            inicio = 1'b0;
            a = ~xa;
            b = ~xb;
            emprestimo_entrada = ~c;
         end
         if (ocupado) busy++;
         if (concluido) begin
            lat = cyc;
            break;
         end
      end
      @(negedge clk);
      pulse = concluido ? 2 : 1;
   endtask

   vec_t tbl[6];
   int lat, busy, pulse;
   logic [N:0] exp;
   logic [N-1:0] ra, rb;
   logic rc;
   int seen[$];

   initial begin
      tbl[0] = '{4'd9, 4'd3, 1'b0, 4'd6,  1'b0};
      tbl[1] = '{4'd3, 4'd9, 1'b0, 4'd10, 1'b1};
      tbl[2] = '{4'd0, 4'd0, 1'b1, 4'd15, 1'b1};
      tbl[3] = '{4'd5, 4'd5, 1'b0, 4'd0,  1'b0};
      tbl[4] = '{4'd8, 4'd1, 1'b0, 4'd7,  1'b0};
      tbl[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};

      #1;
      chk("reset_dif", int'(diferenca), 0);
      chk("reset_bo", int'(emprestimo_saida), 0);
      chk("reset_ocup", int'(ocupado), 0);
      chk("reset_conc", int'(concluido), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat, busy, pulse);
         chk($sformatf("tbl%0d_lat", i), lat, N + 1);
         chk($sformatf("tbl%0d_busy", i), busy, N);
         chk($sformatf("tbl%0d_pulse", i), pulse, 1);
         chk($sformatf("tbl%0d_dif", i), int'(diferenca), int'(tbl[i].d));
         chk($sformatf("tbl%0d_bo", i), int'(emprestimo_saida), int'(tbl[i].bo));
`ifdef SUB_OVERFLOW_EN
         chk($sformatf("tbl%0d_ovf", i), int'(transbordo),
             int'(model_ovf(tbl[i].a, tbl[i].b, tbl[i].d)));
`endif
      end

      for (int i = 0; i < 40; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom);
         exp = model(ra, rb, rc);
         run_op(ra, rb, rc, lat, busy, pulse);
         chk($sformatf("rnd%0d_lat", i), lat, N + 1);
         chk($sformatf("rnd%0d_dif", i), int'(diferenca), int'(exp[N-1:0]));
         chk($sformatf("rnd%0d_bo", i), int'(emprestimo_saida), int'(exp[N]));
`ifdef SUB_OVERFLOW_EN
         chk($sformatf("rnd%0d_ovf", i), int'(transbordo),
             int'(model_ovf(ra, rb, exp[N-1:0])));
`endif
      end

      // inicio held high: accepted every N+2 cycles, a changes mid-CALC.
      run_op(4'd5, 4'd5, 1'b0, lat, busy, pulse);
      @(negedge clk);
      a = 4'd9;
      b = 4'd3;
      emprestimo_entrada = 1'b0;
      inicio = 1'b1;
      seen.delete();
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         if (cyc == 2) a = 4'd15;
         if (cyc == 12) inicio = 1'b0;
         if (cyc == 4) chk("hold_dif_old", int'(diferenca), 0);
         if (cyc == 5) chk("hold_first", int'(diferenca), 6);
         if (cyc == 8) chk("hold_dif_kept", int'(diferenca), 6);
         if (cyc == 11) chk("hold_second", int'(diferenca), 12);
         if (concluido) seen.push_back(cyc);
      end
      chk("hold_npulses", seen.size(), 2);
      chk("hold_pulse0", (seen.size() > 0) ? seen[0] : -1, N + 1);
      chk("hold_pulse1", (seen.size() > 1) ? seen[1] : -1, 2 * N + 3);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      a = 4'd2;
      b = 4'd7;
      inicio = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_dif", int'(diferenca), 0);
      chk("rst_bo", int'(emprestimo_saida), 0);
      chk("rst_ocup", int'(ocupado), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen.delete();
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (concluido || ocupado) seen.push_back(cyc);
      end
      chk("rst_quiet", seen.size(), 0);
      run_op(4'd9, 4'd3, 1'b0, lat, busy, pulse);
      chk("rst_after_lat", lat, N + 1);
      chk("rst_after_dif", int'(diferenca), 6);
      chk("rst_after_bo", int'(emprestimo_saida), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
